rf_access_arbiter: RTL and testbench
====================================

Name: rf_access_arbiter

Overview:
- Shares the register file (two combinational read ports, one write port) between two requesters: requester 0 is the pipeline decode/writeback; requester 1 is the debug/scan unit.
- After reset, it sequences a zero-fill of every register before granting any access.
- At most one requester gets a grant per cycle, using round-robin arbitration with bounded lock bursts.
- Registered read data is returned one cycle after the grant, with write-to-read bypass.

Parameters:
DATA_W, 16, register data width
ADDR_W, 4, register address width
NUM_REGS, 16, registers to zero-fill during INIT (must equal 2**ADDR_W)
MAX_LOCK, 4, max consecutive grants one requester may hold via lock while the other is requesting

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
rN_req  input  1  requester N (N=0,1) wants an access this cycle
rN_lock  input  1  requester N asks to keep the grant next cycle
rN_src1  input  ADDR_W  read address, port 1
rN_src2  input  ADDR_W  read address, port 2
rN_we  input  1  write this access
rN_dst  input  ADDR_W  write address
rN_wdata  input  DATA_W  write data
rN_gnt  output  1  access accepted this cycle (combinational)
rN_rvalid  output  1  registered read data valid (one-cycle pulse)
rN_rdata1  output  DATA_W  registered read data, port 1
rN_rdata2  output  DATA_W  registered read data, port 2
rf_src1  output  ADDR_W  to register file read port 1
rf_src2  output  ADDR_W  to register file read port 2
rf_dst  output  ADDR_W  to register file write address
rf_we  output  1  to register file write enable
rf_wdata  output  DATA_W  to register file write data
rf_rdata1  input  DATA_W  from register file read port 1
rf_rdata2  input  DATA_W  from register file read port 2
busy  output  1  high while INIT runs

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, also mid-operation):
  - state=INIT, init_cnt=0, last_gnt=1 (so r0 wins the first contention), lock_cnt=0, busy=1.
  - All rN_gnt=0, rN_rvalid=0, rN_rdata*=0.
  - Register file outputs driven as for INIT.
- INIT state: runs NUM_REGS cycles.
  - Each cycle: rf_we=1, rf_dst=init_cnt, rf_wdata=0, rf_src*=0, no grants.
  - init_cnt increments each cycle.
  - After the write at init_cnt=NUM_REGS-1, the next state is ARB and busy falls in that same edge's next cycle (first ARB cycle has busy=0).
- ARB state, grant rules (combinational, same cycle):
  - Only one requesting: that requester is granted.
  - Both requesting, lock override: if the requester granted last cycle had rN_lock=1 last cycle, is still requesting, and lock_cnt<MAX_LOCK, it is granted again.
  - Both requesting, otherwise: the requester != last_gnt is granted.
  - Neither requesting: no grant; rf_we=0, rf_src*=0, rf_dst=0, rf_wdata=0.
  - Granted requester's src1/src2/we/dst/wdata are muxed directly onto rf_*.
  - Write commits at the grant-cycle clock edge.
- Edge updates (ARB):
  - last_gnt updates only on a granted cycle.
  - lock_cnt = 1 on the first grant to a new requester, +1 on a consecutive grant to the same requester (saturating at MAX_LOCK), 0 on idle cycles.
  - With the other requester idle, consecutive grants continue regardless of lock_cnt.
- Read return:
  - At the grant edge, rf_rdata1/2 are captured into the granted requester's rN_rdata1/2, and rN_rvalid=1 for exactly the next cycle.
  - The non-granted requester's rdata holds its value and its rvalid is 0.
- Bypass: if the granted access has we=1 and dst==src1 (or src2), the captured rdata for that port is wdata, not rf_rdata.
- Requester requirements: a requester keeps its inputs stable while req=1 and gnt=0. The arbiter never drops a pending request silently; a requester waits at most MAX_LOCK cycles.

Test Plan:
- Reset release: rst low→high; busy=1 for exactly 16 cycles; rf_we=1 with rf_dst 0..15 and wdata=0; no rN_gnt during INIT; busy=0 on cycle 17.
- Single access: r0 writes R3=0x1234, then the next cycle reads src1=3 → r0_rvalid=1 one cycle later with r0_rdata1=0x1234.
- Contention: r0 and r1 both request continuously, no lock → grants alternate r0, r1, r0, r1; each rvalid is a single-cycle pulse to the correct requester.
- Lock bound: r1 holds lock=1 and req=1 while r0 also requests → r1 gets 4 consecutive grants, then r0 is granted on the 5th cycle.
- Bypass: r1 writes R5=0xBEEF and reads src2=5 in the same access → r1_rdata2=0xBEEF the next cycle.
- Reset mid-burst: assert rst during an r0 lock burst → r0_gnt and rvalid drop immediately; INIT reruns the full 16 zero-writes before any new grant.

Source files
------------

// File: rtl/rf_access_arbiter_if.sv
// Requester-side access bundle for rf_access_arbiter: request/lock, register
// addresses and write data in, combinational grant and registered read data out.
interface rf_access_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              req;
  logic              lock;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic              we;
  logic [ADDR_W-1:0] dst;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output req, lock, src1, src2, we, dst, wdata,
    input  gnt, rvalid, rdata1, rdata2
  );

  modport slave (
    input  req, lock, src1, src2, we, dst, wdata,
    output gnt, rvalid, rdata1, rdata2
  );
endinterface

// File: rtl/rf_access_arbiter.sv
// Two-requester register-file arbiter: zero-fills the file after reset, then
// grants round-robin with bounded lock bursts and returns registered read data.
//
// state | meaning
// INIT  | writing zero to register init_cnt, no grants, busy=1
// ARB   | arbitrating r0/r1 onto the register file ports
module rf_access_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              rst,
  rf_access_arbiter_if.slave r0,
  rf_access_arbiter_if.slave r1,
  output logic [ADDR_W-1:0] rf_src1,
  output logic [ADDR_W-1:0] rf_src2,
  output logic [ADDR_W-1:0] rf_dst,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              busy
);
  localparam int LCW = $clog2(MAX_LOCK + 1);

  typedef enum logic {INIT, ARB} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt;
  logic              last_gnt;
  logic              last_lock;
  logic [LCW-1:0]    lock_cnt;
  logic              gnt0, gnt1, pick1;
  logic [DATA_W-1:0] cap1, cap2;

  assign busy   = (state_q == INIT);
  assign r0.gnt = gnt0;
  assign r1.gnt = gnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= INIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    pick1    = 1'b0;
    rf_src1  = '0;
    rf_src2  = '0;
    rf_dst   = '0;
    rf_we    = 1'b0;
    rf_wdata = '0;
    case (state_q)
      INIT: begin
        rf_we  = 1'b1;
        rf_dst = init_cnt;
        if (init_cnt == ADDR_W'(NUM_REGS - 1)) state_d = ARB;
      end
      ARB: begin
        if (r0.req && r1.req) begin
          // last_lock is only set when the previous cycle carried a locked grant
          if (last_lock && (lock_cnt < LCW'(MAX_LOCK))) pick1 = last_gnt;
          else                                           pick1 = ~last_gnt;
          gnt0 = ~pick1;
          gnt1 = pick1;
        end else begin
          gnt0 = r0.req;
          gnt1 = r1.req;
        end
        if (gnt0) begin
          rf_src1  = r0.src1;
          rf_src2  = r0.src2;
          rf_we    = r0.we;
          rf_dst   = r0.dst;
          rf_wdata = r0.wdata;
        end else if (gnt1) begin
          rf_src1  = r1.src1;
          rf_src2  = r1.src2;
          rf_we    = r1.we;
          rf_dst   = r1.dst;
          rf_wdata = r1.wdata;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign cap1 = (rf_we && (rf_dst == rf_src1)) ? rf_wdata : rf_rdata1;
  assign cap2 = (rf_we && (rf_dst == rf_src2)) ? rf_wdata : rf_rdata2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_cnt  <= '0;
      last_gnt  <= 1'b1;
      last_lock <= 1'b0;
      lock_cnt  <= '0;
      r0.rvalid <= 1'b0;
      r0.rdata1 <= '0;
      r0.rdata2 <= '0;
      r1.rvalid <= 1'b0;
      r1.rdata1 <= '0;
      r1.rdata2 <= '0;
    end else begin
      r0.rvalid <= gnt0;
      r1.rvalid <= gnt1;
      if (state_q == INIT) init_cnt <= init_cnt + 1'b1;
      if (gnt0) begin
        r0.rdata1 <= cap1;
        r0.rdata2 <= cap2;
      end
      if (gnt1) begin
        r1.rdata1 <= cap1;
        r1.rdata2 <= cap2;
      end
      if (gnt0 || gnt1) begin
        last_gnt  <= gnt1;
        last_lock <= gnt1 ? r1.lock : r0.lock;
        if ((gnt1 == last_gnt) && (lock_cnt != '0)) begin
          if (lock_cnt != LCW'(MAX_LOCK)) lock_cnt <= lock_cnt + 1'b1;
        end else begin
          lock_cnt <= LCW'(1);
        end
      end else begin
        last_lock <= 1'b0;
        lock_cnt  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: behavioural register file, per-cycle grant
// expectations and a due-cycle scoreboard for the registered read returns.
module tb_rf_access_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  rf_src1, rf_src2, rf_dst;
  logic        rf_we;
  logic [15:0] rf_wdata, rf_rdata1, rf_rdata2;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  rf_access_arbiter_if #(.DATA_W(16), .ADDR_W(4)) r0_if ();
  rf_access_arbiter_if #(.DATA_W(16), .ADDR_W(4)) r1_if ();

  rf_access_arbiter #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(16), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst), .r0(r0_if), .r1(r1_if),
    .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_dst(rf_dst), .rf_we(rf_we),
    .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // register file model, preloaded with junk so the zero-fill is observable
  logic [15:0] mem [16] = '{default: 16'hDEAD};
  always @(posedge clk) if (rf_we) mem[rf_dst] <= rf_wdata;
  assign rf_rdata1 = mem[rf_src1];
  assign rf_rdata2 = mem[rf_src2];

  typedef struct {
    logic        req, lock, we;
    logic [3:0]  s1, s2, dst;
    logic [15:0] wd;
  } rq_t;

  typedef struct {
    logic        who;
    int          due;
    logic [15:0] d1, d2;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] shadow [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic rq_t rq(input logic req, input logic lock, input logic we,
                             input logic [3:0] s1, input logic [3:0] s2,
                             input logic [3:0] dst, input logic [15:0] wd);
    rq_t r;
    r.req = req; r.lock = lock; r.we = we;
    r.s1 = s1; r.s2 = s2; r.dst = dst; r.wd = wd;
    return r;
  endfunction

  task automatic drive(input rq_t a, input rq_t b);
    r0_if.req = a.req; r0_if.lock = a.lock; r0_if.we = a.we; r0_if.src1 = a.s1;
    r0_if.src2 = a.s2; r0_if.dst = a.dst; r0_if.wdata = a.wd;
    r1_if.req = b.req; r1_if.lock = b.lock; r1_if.we = b.we; r1_if.src1 = b.s1;
    r1_if.src2 = b.s2; r1_if.dst = b.dst; r1_if.wdata = b.wd;
  endtask

  task automatic push(input logic who, input rq_t a);
    exp_t e;
    e.who = who;
    e.due = cyc + 1;
    e.d1  = (a.we && a.dst == a.s1) ? a.wd : shadow[a.s1];
    e.d2  = (a.we && a.dst == a.s2) ? a.wd : shadow[a.s2];
    if (a.we) shadow[a.dst] = a.wd;
    sb.push_back(e);
  endtask

  // called at posedge+1; returns at the next posedge+1
  task automatic step(input string tag, input rq_t a, input rq_t b,
                      input logic eg0, input logic eg1);
    drive(a, b);
    @(negedge clk);
    chk({tag, "_gnt0"}, 32'(r0_if.gnt), 32'(eg0));
    chk({tag, "_gnt1"}, 32'(r1_if.gnt), 32'(eg1));
    if (eg0) push(1'b0, a);
    if (eg1) push(1'b1, b);
    @(posedge clk); #1;
  endtask

  task automatic run_init(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk({tag, "_busy"},  32'(busy), 32'd1);
      chk({tag, "_we"},    32'(rf_we), 32'd1);
      chk({tag, "_dst"},   32'(rf_dst), 32'(i));
      chk({tag, "_wdata"}, 32'(rf_wdata), 32'd0);
      chk({tag, "_src1"},  32'(rf_src1), 32'd0);
      chk({tag, "_nogn"},  32'({r0_if.gnt, r1_if.gnt}), 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  // read-return monitor: rvalid must pulse exactly on the due cycle of the head entry
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        logic ev0, ev1;
        ev0 = (sb.size() > 0) && (sb[0].due == cyc) && !sb[0].who;
        ev1 = (sb.size() > 0) && (sb[0].due == cyc) &&  sb[0].who;
        chk("rvalid0", 32'(r0_if.rvalid), 32'(ev0));
        chk("rvalid1", 32'(r1_if.rvalid), 32'(ev1));
        if (ev0 || ev1) begin
          exp_t e;
          e = sb.pop_front();
          chk(ev0 ? "r0_rdata1" : "r1_rdata1", 32'(ev0 ? r0_if.rdata1 : r1_if.rdata1), 32'(e.d1));
          chk(ev0 ? "r0_rdata2" : "r1_rdata2", 32'(ev0 ? r0_if.rdata2 : r1_if.rdata2), 32'(e.d2));
        end
      end
    end
  end

  initial begin
    rq_t idle, rd3, wr3, r0c, r1c, r1l, r0l, byp;
    idle = rq(0, 0, 0, 4'd0, 4'd0, 4'd0, 16'h0);
    rd3  = rq(1, 0, 0, 4'd3, 4'd7, 4'd0, 16'h0);
    wr3  = rq(1, 0, 1, 4'd0, 4'd0, 4'd3, 16'h1234);
    r0c  = rq(1, 0, 0, 4'd3, 4'd1, 4'd0, 16'h0);
    r1c  = rq(1, 0, 0, 4'd2, 4'd3, 4'd0, 16'h0);
    r1l  = rq(1, 1, 0, 4'd3, 4'd0, 4'd0, 16'h0);
    r0l  = rq(1, 1, 0, 4'd3, 4'd4, 4'd0, 16'h0);
    byp  = rq(1, 0, 1, 4'd3, 4'd5, 4'd5, 16'hBEEF);
    foreach (shadow[i]) shadow[i] = 16'h0;

    drive(rd3, idle);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   32'(busy), 32'd1);
    chk("rst_gnt0",   32'(r0_if.gnt), 32'd0);
    chk("rst_rvalid", 32'({r0_if.rvalid, r1_if.rvalid}), 32'd0);
    chk("rst_rdata",  32'(r0_if.rdata1), 32'd0);
    rst = 1'b1;
    run_init("init");
    step("first_rd", rd3, idle, 1, 0);

    step("wr_r3", wr3, idle, 1, 0);
    step("rd_r3", rd3, idle, 1, 0);
    step("idle1", idle, idle, 0, 0);

    // last grant was r0, so contention starts with r1
    step("cont1", r0c, r1c, 0, 1);
    step("cont2", r0c, r1c, 1, 0);
    step("cont3", r0c, r1c, 0, 1);
    step("cont4", r0c, r1c, 1, 0);
    step("idle2", idle, idle, 0, 0);

    for (int i = 0; i < 4; i++) step("lock_r1", r0c, r1l, 0, 1);
    step("lock_end", r0c, r1l, 1, 0);
    step("lock_rr", r0c, r1l, 0, 1);
    step("idle3", idle, idle, 0, 0);

    step("bypass", idle, byp, 0, 1);
    step("idle4", idle, idle, 0, 0);

    step("burst1", r0l, idle, 1, 0);
    step("burst2", r0l, idle, 1, 0);
    rst = 1'b0;
    #1;
    chk("mid_gnt0",   32'(r0_if.gnt), 32'd0);
    chk("mid_rvalid", 32'(r0_if.rvalid), 32'd0);
    chk("mid_rdata",  32'(r0_if.rdata1), 32'd0);
    chk("mid_busy",   32'(busy), 32'd1);
    sb.delete();
    foreach (shadow[i]) shadow[i] = 16'h0;
    @(posedge clk); #1;
    rst = 1'b1;
    run_init("reinit");
    step("post_rd", rd3, idle, 1, 0);
    step("idle5", idle, idle, 0, 0);
    step("idle6", idle, idle, 0, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
